// File: rtl/muxp_rr_if.sv
// -----------------------------------------------------------------------------
// muxp_rr_if : handshake and data bundle for the muxp_rr operand selector.
//
// Signals (all named from the point of view of the selector):
//   mode    : 0 = direct (sel picks the channel), 1 = round-robin
//   sel     : channel index for direct mode
//   din     : N flattened W-bit channel words; channel k is din[k*W +: W]
//   vin     : per-channel valid
//   ack     : one-hot pop strobe back to the channel being captured
//   sal     : registered output word
//   sal_ch  : index of the channel that produced sal
//   sal_v   : sal holds a valid word
//   sal_rdy : downstream accepts sal this cycle
//
// Modports:
//   slave  : the selector itself
//   master : the environment that drives the sources and the sink
// -----------------------------------------------------------------------------
interface muxp_rr_if #(
   parameter int unsigned W    = 5,
   parameter int unsigned N    = 4,
   parameter int unsigned SELW = 2
);
   logic              mode;
   logic [SELW-1:0]   sel;
   logic [N*W-1:0]    din;
   logic [N-1:0]      vin;
   logic [N-1:0]      ack;
   logic [W-1:0]      sal;
   logic [SELW-1:0]   sal_ch;
   logic              sal_v;
   logic              sal_rdy;

   modport slave (
      input  mode, sel, din, vin, sal_rdy,
      output ack, sal, sal_ch, sal_v
   );

   modport master (
      output mode, sel, din, vin, sal_rdy,
      input  ack, sal, sal_ch, sal_v
   );
endinterface

// File: rtl/muxp_rr.sv
// -----------------------------------------------------------------------------
// muxp_rr : registered N:1 operand selector with direct and round-robin modes.
//
// Picks one of N W-bit source channels into a single output register. In
// direct mode the external sel chooses the channel; in round-robin mode a
// rotating pointer scans from ptr upward (modulo N) for the first valid
// channel. Both sides use valid/ready; a word can be drained and a new one
// captured on the same edge, so throughput is one word per clock.
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   bus      : muxp_rr_if.slave (mode, sel, din, vin, ack, sal, sal_ch,
//              sal_v, sal_rdy)
//   xfer_cnt : [15:0] saturating count of completed output transfers
//              (present only when MUXP_RR_XFER_CNT_EN is defined)
//
// Optional feature macro: MUXP_RR_XFER_CNT_EN
// -----------------------------------------------------------------------------
module muxp_rr #(
   parameter int unsigned W    = 5,
   parameter int unsigned N    = 4,
   parameter int unsigned SELW = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   muxp_rr_if.slave     bus
`ifdef MUXP_RR_XFER_CNT_EN
   ,
   output logic [15:0]  xfer_cnt
`endif
);

   localparam int unsigned NP = 2 ** SELW;

   logic [SELW-1:0] ptr_q, ptr_d;
   logic [W-1:0]    sal_q, sal_d;
   logic [SELW-1:0] sal_ch_q, sal_ch_d;
   logic            sal_v_q, sal_v_d;

   logic [NP-1:0]   vin_pad;
   logic [SELW-1:0] rr_idx;
   logic            rr_found;
   logic [SELW-1:0] grant_idx;
   logic            grant_valid;
   logic [W-1:0]    grant_data;
   logic            load;
   logic [N-1:0]    ack;

   // Round-robin scan: first valid channel at or after ptr, wrapping modulo N.
   always_comb begin : rr_scan
      int unsigned c;
      // NOTE: every variable gets a default before any conditional assignment,
      // otherwise synthesis infers a latch to hold the old value.
      rr_found = 1'b0;
      rr_idx   = '0;
      c        = 0;
      for (int unsigned i = 0; i < N; i++) begin
         c = int'(ptr_q) + i;
         if (c >= N) c = c - N;
         if (!rr_found && bus.vin[c]) begin
            rr_found = 1'b1;
            rr_idx   = SELW'(c);
         end
      end
   end

   // Grant selection and output-register next state.
   always_comb begin
      // Zero-extending vin to 2**SELW entries makes any sel >= N read a 0.
      vin_pad         = '0;
      vin_pad[N-1:0]  = bus.vin;

      if (bus.mode) begin
         grant_idx   = rr_idx;
         grant_valid = rr_found;
      end else begin
         grant_idx   = bus.sel;
         grant_valid = vin_pad[bus.sel];
      end

      grant_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (grant_idx == SELW'(k)) grant_data = bus.din[k*W +: W];
      end

      // rst_n gates load so ack is silent while reset is held.
      load = rst_n & (~sal_v_q | bus.sal_rdy) & grant_valid;

      ack = '0;
      for (int unsigned k = 0; k < N; k++) begin
         ack[k] = load & (grant_idx == SELW'(k));
      end

      sal_d    = sal_q;
      sal_ch_d = sal_ch_q;
      sal_v_d  = sal_v_q;
      ptr_d    = ptr_q;

      if (load) begin
         sal_d    = grant_data;
         sal_ch_d = grant_idx;
         sal_v_d  = 1'b1;
         if (bus.mode) begin
            ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
         end
      end else if (bus.sal_rdy) begin
         // Drain without refill: data and channel keep their last value.
         sal_v_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its _d value from before the edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         sal_q    <= '0;
         sal_ch_q <= '0;
         sal_v_q  <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         sal_q    <= sal_d;
         sal_ch_q <= sal_ch_d;
         sal_v_q  <= sal_v_d;
      end
   end

   assign bus.ack    = ack;
   assign bus.sal    = sal_q;
   assign bus.sal_ch = sal_ch_q;
   assign bus.sal_v  = sal_v_q;

`ifdef MUXP_RR_XFER_CNT_EN
   logic [15:0] xfer_cnt_q, xfer_cnt_d;

   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      if (sal_v_q && bus.sal_rdy && (xfer_cnt_q != 16'hFFFF)) begin
         xfer_cnt_d = xfer_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) xfer_cnt_q <= '0;
      else        xfer_cnt_q <= xfer_cnt_d;
   end

   assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_muxp_rr.sv
// -----------------------------------------------------------------------------
// tb_muxp_rr : directed bench for muxp_rr.
//
// Inputs change 1 time unit after a rising edge; the combinational ack is
// checked 1 unit later, and registered outputs are checked 1 unit after the
// following rising edge. A second instance with N=3 covers modulo-N wrap and
// the out-of-range direct select.
// -----------------------------------------------------------------------------
module tb_muxp_rr;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   muxp_rr_if #(.W(5), .N(4), .SELW(2)) b4 ();
   muxp_rr_if #(.W(5), .N(3), .SELW(2)) b3 ();

`ifdef MUXP_RR_XFER_CNT_EN
   logic [15:0] cnt4, cnt3;
`endif

   muxp_rr #(.W(5), .N(4), .SELW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b4.slave)
`ifdef MUXP_RR_XFER_CNT_EN
      , .xfer_cnt (cnt4)
`endif
   );

   muxp_rr #(.W(5), .N(3), .SELW(2)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b3.slave)
`ifdef MUXP_RR_XFER_CNT_EN
      , .xfer_cnt (cnt3)
`endif
   );

   // Channel words: ch0=03, ch1=0A, ch2=15, ch3=1C
   localparam logic [19:0] DIN4 = {5'h1C, 5'h15, 5'h0A, 5'h03};
   localparam logic [14:0] DIN3 = {5'h15, 5'h0A, 5'h03};

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic [3:0] vin;
      logic       rdy;
      logic [3:0] ack;   // expected combinational ack
      logic       v;     // expected sal_v after the edge
      logic [4:0] sal;   // expected sal after the edge
      logic [1:0] ch;    // expected sal_ch after the edge
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [4:0] sal,
                            input logic [1:0] ch);
      check({tag, " sal_v"},  32'(b4.sal_v),  32'(v));
      check({tag, " sal"},    32'(b4.sal),    32'(sal));
      check({tag, " sal_ch"}, 32'(b4.sal_ch), 32'(ch));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Direct-mode transfers, miss, then round-robin from ptr=0.
      vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 5'h15, 2'd2};
      vecs[1]  = '{1'b0, 2'd3, 4'b0100, 1'b1, 4'b0000, 1'b0, 5'h15, 2'd2};
      vecs[2]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 5'h0A, 2'd1};
      vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 5'h03, 2'd0};
      vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 5'h0A, 2'd1};
      vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 5'h15, 2'd2};
      vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 5'h1C, 2'd3};
      vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 5'h03, 2'd0};
      vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 5'h0A, 2'd1};
      // ptr=2: take ch0 to set ptr=1, then skip test with vin=1001.
      vecs[9]  = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 5'h03, 2'd0};
      vecs[10] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 5'h1C, 2'd3};
      vecs[11] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 5'h03, 2'd0};
      // No valid: drain. Then direct capture into empty reg with rdy=0 (ptr stays 1).
      vecs[12] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 5'h03, 2'd0};
      vecs[13] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0001, 1'b1, 5'h03, 2'd0};
      // Backpressure for 3 cycles, then drain and refill from ptr=1.
      vecs[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 5'h03, 2'd0};
      vecs[15] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 5'h03, 2'd0};
      vecs[16] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 5'h03, 2'd0};
      vecs[17] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 5'h0A, 2'd1};
      vecs[18] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 5'h0A, 2'd1};
      vecs[19] = '{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 5'h0A, 2'd1};

      b4.din = DIN4;  b4.mode = 1'b1; b4.sel = '0; b4.vin = 4'b1111; b4.sal_rdy = 1'b1;
      b3.din = DIN3;  b3.mode = 1'b1; b3.sel = '0; b3.vin = 3'b000;  b3.sal_rdy = 1'b1;

      // Reset held for two edges with all channels valid.
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst%0d ack", i), 32'(b4.ack), 32'h0);
         step();
         check_out($sformatf("rst%0d", i), 1'b0, 5'h00, 2'd0);
      end

      // Release: capture of ch0 at the next edge.
      rst_n = 1'b1;
      #1;
      check("release ack", 32'(b4.ack), 32'b0001);
      step();
      check_out("release", 1'b1, 5'h03, 2'd0);

      // Reset while a word is held and stalled: discarded, no ack.
      b4.sal_rdy = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst ack", 32'(b4.ack), 32'h0);
      step();
      check_out("midrst", 1'b0, 5'h00, 2'd0);
      rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < 20; i++) begin
         b4.mode = vecs[i].mode;
         b4.sel = vecs[i].sel;
         b4.vin = vecs[i].vin;
         b4.sal_rdy = vecs[i].rdy;
         #1;
         check($sformatf("v%0d ack", i), 32'(b4.ack), 32'(vecs[i].ack));
         step();
         check_out($sformatf("v%0d", i), vecs[i].v, vecs[i].sal, vecs[i].ch);
      end

      // N=3 instance: wrap modulo 3, index 3 never produced.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      b3.mode = 1'b1; b3.vin = 3'b111; b3.sal_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("n3 rr%0d ack", i), 32'(b3.ack), 32'(3'b001 << (i % 3)));
         step();
         check($sformatf("n3 rr%0d sal_ch", i), 32'(b3.sal_ch), 32'(i % 3));
         check($sformatf("n3 rr%0d sal", i), 32'(b3.sal), 32'(DIN3 >> (5 * (i % 3))) & 32'h1F);
      end
      // Direct sel=3 on a 3-channel instance never grants.
      b3.mode = 1'b0; b3.sel = 2'd3;
      #1;
      check("n3 sel3 ack", 32'(b3.ack), 32'h0);
      step();
      check("n3 sel3 sal_v", 32'(b3.sal_v), 32'h0);
      b3.sel = 2'd2;
      #1;
      check("n3 sel2 ack", 32'(b3.ack), 32'b100);
      step();
      check("n3 sel2 sal_ch", 32'(b3.sal_ch), 32'd2);

`ifdef MUXP_RR_XFER_CNT_EN
      // Transfer counter: one fill edge then 5 completed transfers.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("cnt reset", 32'(cnt4), 32'h0);
      b4.mode = 1'b1; b4.vin = 4'b1111; b4.sal_rdy = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("cnt five", 32'(cnt4), 32'd5);
      for (int i = 0; i < 65529; i++) step();
      check("cnt fffe", 32'(cnt4), 32'hFFFE);
      for (int i = 0; i < 3; i++) step();
      check("cnt sat", 32'(cnt4), 32'hFFFF);
      rst_n = 1'b0;
      step();
      check("cnt rst", 32'(cnt4), 32'h0);
      rst_n = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muxp_rr.md
Name: muxp_rr

Overview:
- Parametrised, registered successor to the 4:1 5-bit operand mux in the datapath.
- Selects one of N W-bit source channels into a single output register, in one of two modes:
  - direct mode: an external select picks the channel;
  - round-robin mode: an internal rotating pointer picks the next valid channel.
- Each transfer uses a valid/ready handshake on both sides.
- Sits between register-file/immediate sources and the ALU operand latch, so several producers can share one operand path.

Parameters:
- W, 5, data width of each channel and of the output.
- N, 4, number of input channels (2..16).
- SELW, 2, width of sel and sal_ch. Must satisfy N <= 2**SELW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- mode  input  1  selects the policy: 0 = direct (use sel), 1 = round-robin.
- sel  input  SELW  channel index used in direct mode.
- din  input  N*W  flattened channel data; channel k occupies din[k*W +: W].
- vin  input  N  per-channel valid.
- ack  output  N  one-hot; ack[k]=1 means channel k's word is captured at this clk edge.
- sal  output  W  registered output data.
- sal_ch  output  SELW  index of the channel that produced sal.
- sal_v  output  1  sal holds a valid word.
- sal_rdy  input  1  downstream accepts sal this cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - sal=0, sal_ch=0, sal_v=0, round-robin pointer ptr=0.
  - ack is forced to 0 while rst_n=0.
  - Reset mid-transfer discards the held word with no ack.
- Capture condition: load = (!sal_v | sal_rdy) & grant_valid.
  - Draining and refilling in the same cycle is allowed, giving full throughput of 1 word/cycle.
  - Latency is 1 clk from ack to sal_v.
- Direct mode (mode=0):
  - Candidate channel c = sel. grant_valid = (sel < N) & vin[sel].
  - sel >= N never grants; the output simply drains.
- Round-robin mode (mode=1):
  - Scan channels ptr, ptr+1, ... ptr+N-1, wrapping modulo N (not 2**SELW). The first channel with vin set wins.
  - If no vin is set, there is no grant.
  - On each load in this mode, ptr <= (granted+1) mod N; wrap from N-1 to 0.
  - ptr is unchanged in direct mode and on cycles without a load.
- ack:
  - Combinational and one-hot, asserted only when load=1: ack[c] = load & (c == granted).
  - Sources must treat ack as a pop in that cycle.
- On load: sal <= din[granted], sal_ch <= granted, sal_v <= 1.
- On drain without refill (sal_v & sal_rdy & !grant_valid): sal_v <= 0. sal and sal_ch hold their last value.
- Stall (sal_v & !sal_rdy):
  - sal, sal_ch and sal_v are held stable.
  - ack = 0 regardless of vin.
- A mode change takes effect in the same cycle it is applied and does not reset ptr.
- No combinational path from sal_rdy to sal or sal_v. The paths sal_rdy→ack and vin/sel/mode→ack are permitted.

Optional Feature:
- Macro: MUXP_RR_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [15:0], a count of completed output transfers (sal_v & sal_rdy).
  - The counter saturates at 16'hFFFF and is reset to 0 by rst_n.
- Not defined: port xfer_cnt and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with vin=4'b1111 → ack=0, sal=0, sal_v=0, sal_ch=0. Release → first capture one cycle later.
- Direct mode:
  - mode=0, sel=2, din ch2=5'h15, vin=4'b0100, sal_rdy=1 → ack=4'b0100 in the same cycle; next cycle sal=5'h15, sal_ch=2, sal_v=1.
  - Then sel=3 with vin[3]=0 → ack=0; sal_v drops to 0 the following cycle.
- Round-robin fairness and wrap:
  - mode=1, vin=4'b1111, sal_rdy=1 continuously → sal_ch sequence 0,1,2,3,0,1 (wraps from N-1 to 0).
  - With N=3 and SELW=2 → sequence 0,1,2,0, and index 3 is never produced.
- Round-robin skip: mode=1, ptr=1, vin=4'b1001 → grant ch3, then ptr=0 → next grant ch0.
- Backpressure: sal_v=1, sal_rdy=0 for 3 cycles with vin=4'b1111 → sal and sal_ch stable, ack=0 each cycle. Raise sal_rdy → drain and refill in the same cycle.
- With MUXP_RR_XFER_CNT_EN defined:
  - 5 completed transfers → xfer_cnt=5.
  - Preload the count to 16'hFFFE, then 3 more transfers → xfer_cnt=16'hFFFF.
  - rst_n=0 → xfer_cnt=0.
